// File: rtl/output_sched_pkg.sv
// output_sched_pkg
//   Shared types and constants for the output bank scheduler.
//   - sched_state_e          : scheduler FSM state encoding
//   - TIMEOUT_CYCLES_DEFAULT : default fetch watchdog limit in clock cycles
package output_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    localparam logic [15:0] TIMEOUT_CYCLES_DEFAULT = 16'd4096;

endpackage

// File: rtl/output_sched_watchdog.sv
// output_sched_watchdog
//   16-bit saturating cycle counter that bounds how long a fetch may run.
//   Ports:
//     clock    in  : rising-edge clock
//     reset_n  in  : asynchronous active-low reset
//     clear    in  : synchronous clear to zero (has priority over count_en)
//     count_en in  : increment by one this cycle (saturates at 16'hFFFF)
//     terminal out : count_en high and count has reached TIMEOUT_CYCLES-1
module output_sched_watchdog
    import output_sched_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic count_en,
    output logic terminal
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Count value c is present during the (c+1)-th counting cycle, so terminal at
    // TIMEOUT_CYCLES-1 ends the fetch after exactly TIMEOUT_CYCLES counting cycles.
    assign terminal = count_en && (count_q == (TIMEOUT_CYCLES - 16'd1));

endmodule

// File: rtl/output_bank_scheduler.sv
// output_bank_scheduler
//   Ping-pong scheduler between a producer filling two output banks and a fetch
//   engine draining them. Tracks per-bank full flags, launches one fetch per full
//   bank in order, and aborts fetches that exceed TIMEOUT_CYCLES.
//   Ports:
//     clock         in  : rising-edge clock
//     reset_n       in  : asynchronous active-low reset
//     enable        in  : permits launching new fetches
//     wr_bank_done  in  : producer finished filling bank wr_bank (one-cycle pulse)
//     wr_bank       out : bank the producer writes next
//     wr_bank_ready out : bank wr_bank is free (combinational)
//     fetch_start   out : level start to the fetch engine
//     fetch_base    out : bank being fetched
//     fetch_done    in  : level done from fetch engine, held until fetch_start drops
//     frames_out    out : completed frame count, wraps at 8 bits
//     timeout_err   out : sticky, a fetch was aborted by the watchdog
//     overrun_err   out : sticky, wr_bank_done arrived while wr_bank_ready was low
//     busy          out : FSM not in IDLE
module output_bank_scheduler
    import output_sched_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       wr_bank_done,
    output logic       wr_bank,
    output logic       wr_bank_ready,
    output logic       fetch_start,
    output logic       fetch_base,
    input  logic       fetch_done,
    output logic [7:0] frames_out,
    output logic       timeout_err,
    output logic       overrun_err,
    output logic       busy
);

    sched_state_e state_q, state_d;
    logic [1:0]   full_q, full_d;
    logic         wr_bank_q, wr_bank_d;
    logic         rd_bank_q, rd_bank_d;
    logic         fetch_start_q, fetch_start_d;
    logic         fetch_base_q, fetch_base_d;
    logic [7:0]   frames_q, frames_d;
    logic         timeout_q, timeout_d;
    logic         overrun_q, overrun_d;
    logic         busy_q, busy_d;
    logic         rd_release;
    logic         wd_terminal;

    output_sched_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (state_q == IDLE),
        .count_en (state_q == RUN),
        .terminal (wd_terminal)
    );

    assign wr_bank_ready = !full_q[wr_bank_q];

    always_comb begin
        state_d       = state_q;
        full_d        = full_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        fetch_start_d = fetch_start_q;
        fetch_base_d  = fetch_base_q;
        frames_d      = frames_q;
        timeout_d     = timeout_q;
        overrun_d     = overrun_q;
        rd_release    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable && full_q[rd_bank_q]) begin
                    state_d       = RUN;
                    fetch_start_d = 1'b1;
                    fetch_base_d  = rd_bank_q;
                end
            end
            RUN: begin
                // Completion is checked first so it wins over a same-cycle expiry.
                if (fetch_done) begin
                    state_d       = DRAIN;
                    fetch_start_d = 1'b0;
                    rd_release    = 1'b1;
                    frames_d      = frames_q + 8'd1;
                end else if (wd_terminal) begin
                    state_d       = DRAIN;
                    fetch_start_d = 1'b0;
                    rd_release    = 1'b1;
                    timeout_d     = 1'b1;
                end
            end
            DRAIN: begin
                if (!fetch_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d       = IDLE;
                fetch_start_d = 1'b0;
            end
        endcase

        // Write side and read side never hit the same bank: the read bank is full
        // while the accepted write bank is free, so both updates can coexist.
        if (wr_bank_done) begin
            if (wr_bank_ready) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (rd_release) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            full_q        <= 2'b00;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            fetch_start_q <= 1'b0;
            fetch_base_q  <= 1'b0;
            frames_q      <= 8'h00;
            timeout_q     <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            full_q        <= full_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            fetch_start_q <= fetch_start_d;
            fetch_base_q  <= fetch_base_d;
            frames_q      <= frames_d;
            timeout_q     <= timeout_d;
            overrun_q     <= overrun_d;
            busy_q        <= busy_d;
        end
    end

    assign wr_bank     = wr_bank_q;
    assign fetch_start = fetch_start_q;
    assign fetch_base  = fetch_base_q;
    assign frames_out  = frames_q;
    assign timeout_err = timeout_q;
    assign overrun_err = overrun_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_output_bank_scheduler.sv
// tb_output_bank_scheduler
//   Scoreboard bench: each accepted wr_bank_done pushes the expected frame
//   (bank, frame count) and a monitor pops and compares on each fetch completion.
//   A second instance with TIMEOUT_CYCLES=16 exercises the watchdog abort.
`timescale 1ns/1ps
module tb_output_bank_scheduler;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Main instance (default timeout)
    logic       reset_n, enable, wr_bank_done, fetch_done;
    logic       wr_bank, wr_bank_ready, fetch_start, fetch_base;
    logic       timeout_err, overrun_err, busy;
    logic [7:0] frames_out;

    // Short-timeout instance
    logic       t_reset_n, t_enable, t_wr_done, t_fetch_done;
    logic       t_wr_bank, t_wr_ready, t_fetch_start, t_fetch_base;
    logic       t_timeout_err, t_overrun_err, t_busy;
    logic [7:0] t_frames_out;

    output_bank_scheduler dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .wr_bank_done  (wr_bank_done),
        .wr_bank       (wr_bank),
        .wr_bank_ready (wr_bank_ready),
        .fetch_start   (fetch_start),
        .fetch_base    (fetch_base),
        .fetch_done    (fetch_done),
        .frames_out    (frames_out),
        .timeout_err   (timeout_err),
        .overrun_err   (overrun_err),
        .busy          (busy)
    );

    output_bank_scheduler #(
        .TIMEOUT_CYCLES (16'd16)
    ) dut_t (
        .clock         (clock),
        .reset_n       (t_reset_n),
        .enable        (t_enable),
        .wr_bank_done  (t_wr_done),
        .wr_bank       (t_wr_bank),
        .wr_bank_ready (t_wr_ready),
        .fetch_start   (t_fetch_start),
        .fetch_base    (t_fetch_base),
        .fetch_done    (t_fetch_done),
        .frames_out    (t_frames_out),
        .timeout_err   (t_timeout_err),
        .overrun_err   (t_overrun_err),
        .busy          (t_busy)
    );

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic       base;
        logic [7:0] frames;
    } frame_t;

    frame_t     exp_q[$];
    logic       exp_wr;
    logic [7:0] exp_frames;
    int         fetch_latency;
    int         drain_hold;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Producer pulse expected to be accepted; records the frame it will become.
    task automatic pulse_a();
        frame_t e;
        wr_bank_done = 1'b1;
        exp_frames   = exp_frames + 8'd1;
        e.base       = exp_wr;
        e.frames     = exp_frames;
        exp_q.push_back(e);
        exp_wr = ~exp_wr;
        @(posedge clock); #1;
        wr_bank_done = 1'b0;
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    // Fetch engine model: raises done fetch_latency cycles after start, drops it
    // drain_hold cycles after start falls.
    initial begin
        int run_cnt;
        int hold_cnt;
        run_cnt    = 0;
        hold_cnt   = 0;
        fetch_done = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (!reset_n) begin
                fetch_done = 1'b0;
                run_cnt    = 0;
                hold_cnt   = 0;
            end else if (fetch_start && !fetch_done) begin
                run_cnt++;
                if (run_cnt >= fetch_latency) fetch_done = 1'b1;
            end else if (!fetch_start && fetch_done) begin
                run_cnt = 0;
                if (hold_cnt >= drain_hold) begin
                    fetch_done = 1'b0;
                    hold_cnt   = 0;
                end else begin
                    hold_cnt++;
                end
            end
        end
    end

    // Monitor: every falling fetch_start outside reset is a completed frame.
    initial begin
        logic   prev_fs;
        logic   base_seen;
        frame_t e;
        prev_fs   = 1'b0;
        base_seen = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (!reset_n) begin
                prev_fs = 1'b0;
            end else begin
                if (prev_fs && !fetch_start) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_frame: got frame %0d, expected none (t=%0t)",
                                 frames_out, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_base", {31'd0, base_seen}, {31'd0, e.base});
                        check("frame_count", {24'd0, frames_out}, {24'd0, e.frames});
                        check("frame_no_timeout", {31'd0, timeout_err}, 32'd0);
                    end
                end
                if (fetch_start) base_seen = fetch_base;
                prev_fs = fetch_start;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        int  n;
        bit  seen;
        reset_n       = 1'b0;
        enable        = 1'b0;
        wr_bank_done  = 1'b0;
        t_reset_n     = 1'b0;
        t_enable      = 1'b0;
        t_wr_done     = 1'b0;
        t_fetch_done  = 1'b0;
        exp_wr        = 1'b0;
        exp_frames    = 8'd0;
        fetch_latency = 263;
        drain_hold    = 3;
        repeat (3) step();

        // Reset values
        check("rst_wr_bank", {31'd0, wr_bank}, 32'd0);
        check("rst_wr_ready", {31'd0, wr_bank_ready}, 32'd1);
        check("rst_fetch_start", {31'd0, fetch_start}, 32'd0);
        check("rst_fetch_base", {31'd0, fetch_base}, 32'd0);
        check("rst_frames", {24'd0, frames_out}, 32'd0);
        check("rst_errs", {30'd0, timeout_err, overrun_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        reset_n   = 1'b1;
        t_reset_n = 1'b1;
        enable    = 1'b1;
        step();

        // Single frame, 263-cycle fetch, 3-cycle drain
        pulse_a();
        check("wr_toggle", {31'd0, wr_bank}, 32'd1);
        step();
        check("launch_start", {31'd0, fetch_start}, 32'd1);
        check("launch_base", {31'd0, fetch_base}, 32'd0);
        check("launch_busy", {31'd0, busy}, 32'd1);
        n = 0;
        while (fetch_start && n < 400) begin step(); n++; end
        check("start_high_cycles", n, 32'd263);
        check("first_frames", {24'd0, frames_out}, 32'd1);
        check("drain_busy", {31'd0, busy}, 32'd1);
        n = 0;
        while (busy && n < 50) begin step(); n++; end
        check("drain_cycles", n, 32'd4);

        // Overrun: fill both banks with enable low, third pulse overruns
        reset_n = 1'b0;
        exp_q.delete();
        exp_wr     = 1'b0;
        exp_frames = 8'd0;
        repeat (2) step();
        reset_n       = 1'b1;
        enable        = 1'b0;
        fetch_latency = 5;
        drain_hold    = 0;
        step();
        pulse_a();
        pulse_a();
        wr_bank_done = 1'b1;
        step();
        wr_bank_done = 1'b0;
        check("ovr_err", {31'd0, overrun_err}, 32'd1);
        check("ovr_ready", {31'd0, wr_bank_ready}, 32'd0);
        check("ovr_wr_bank", {31'd0, wr_bank}, 32'd0);
        check("ovr_no_launch", {31'd0, fetch_start}, 32'd0);
        enable = 1'b1;
        n = 0;
        while (!fetch_start && n < 20) begin step(); n++; end
        n = 0;
        while (fetch_start && n < 50) begin step(); n++; end
        check("bank0_freed_ready", {31'd0, wr_bank_ready}, 32'd1);
        check("bank0_freed_wr_bank", {31'd0, wr_bank}, 32'd0);
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin step(); n++; end
        check("ovr_queue_drained", exp_q.size(), 32'd0);

        // Reset mid-RUN
        fetch_latency = 50;
        pulse_a();
        repeat (5) step();
        check("mid_run_start", {31'd0, fetch_start}, 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_fetch_start", {31'd0, fetch_start}, 32'd0);
        check("async_busy", {31'd0, busy}, 32'd0);
        check("async_errs", {30'd0, timeout_err, overrun_err}, 32'd0);
        check("async_frames", {24'd0, frames_out}, 32'd0);
        check("async_banks", {29'd0, wr_bank, wr_bank_ready, fetch_base}, 32'b010);
        exp_q.delete();
        exp_wr     = 1'b0;
        exp_frames = 8'd0;
        repeat (2) step();
        reset_n = 1'b1;
        seen    = 1'b0;
        repeat (10) begin step(); if (fetch_start || busy) seen = 1'b1; end
        check("no_relaunch", {31'd0, seen}, 32'd0);

        // 256 frames: count wraps to zero
        fetch_latency = 2;
        for (int i = 0; i < 256; i++) begin
            n = 0;
            while (!wr_bank_ready && n < 50) begin step(); n++; end
            if (n >= 50) begin
                checks++;
                $display("FAIL wrap_ready_wait: got ready=0, expected ready=1 (t=%0t)", $time);
                break;
            end
            pulse_a();
        end
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin step(); n++; end
        check("wrap_queue_drained", exp_q.size(), 32'd0);
        check("frames_wrap", {24'd0, frames_out}, 32'd0);

        // enable low with a full bank: no launch until enabled
        enable = 1'b0;
        pulse_a();
        seen = 1'b0;
        repeat (20) begin step(); if (fetch_start) seen = 1'b1; end
        check("disabled_no_start", {31'd0, seen}, 32'd0);
        enable = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin step(); n++; end
        check("enabled_queue_drained", exp_q.size(), 32'd0);
        check("enabled_frames", {24'd0, frames_out}, 32'd1);

        // Watchdog abort on the short-timeout instance
        t_enable  = 1'b1;
        t_wr_done = 1'b1;
        step();
        t_wr_done = 1'b0;
        n = 0;
        while (!t_fetch_start && n < 10) begin step(); n++; end
        check("t_launch", {31'd0, t_fetch_start}, 32'd1);
        n = 0;
        while (t_fetch_start && n < 100) begin step(); n++; end
        check("t_run_cycles", n, 32'd16);
        check("t_timeout_err", {31'd0, t_timeout_err}, 32'd1);
        check("t_frames", {24'd0, t_frames_out}, 32'd0);
        check("t_overrun", {31'd0, t_overrun_err}, 32'd0);
        t_wr_done = 1'b1;
        step();
        t_wr_done = 1'b0;
        n = 0;
        while (!t_fetch_start && n < 10) begin step(); n++; end
        check("t_second_launch", {31'd0, t_fetch_start}, 32'd1);
        check("t_second_base", {31'd0, t_fetch_base}, 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/output_bank_scheduler.md
OUTPUT_BANK_SCHEDULER -- requirements
Module: output_bank_scheduler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16'd4096, max cycles a fetch may run before abort.
REQ-002 Port: clock  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: reset_n  input  1  asynchronous active-low reset.
REQ-004 Port: enable  input  1  level; permits launching new fetches.
REQ-005 Port: wr_bank_done  input  1  one-cycle pulse; producer finished filling bank wr_bank.
REQ-006 Port: wr_bank  output  1  bank the producer SHALL write next (address bit 15).
REQ-007 Port: wr_bank_ready  output  1  high when bank wr_bank is free for writing.
REQ-008 Port: fetch_start  output  1  level start to the output fetch engine.
REQ-009 Port: fetch_base  output  1  bank select to the fetch engine base-offset input.
REQ-010 Port: fetch_done  input  1  level done from the fetch engine; stays high until fetch_start drops.
REQ-011 Port: frames_out  output  8  count of completed frames, wraps 8'hFF->8'h00.
REQ-012 Port: timeout_err  output  1  sticky; a fetch exceeded TIMEOUT_CYCLES.
REQ-013 Port: overrun_err  output  1  sticky; wr_bank_done received while wr_bank_ready low.
REQ-014 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-015 Block SHALL keep full[1:0], write pointer wr_bank, read pointer rd_bank; wr_bank_ready = !full[wr_bank] (combinational).
REQ-016 wr_bank_done with wr_bank_ready high SHALL set full[wr_bank] and toggle wr_bank next cycle; with wr_bank_ready low SHALL be ignored and set overrun_err.
REQ-017 FSM states: IDLE, RUN, DRAIN; all outputs except wr_bank_ready SHALL be registered.
REQ-018 IDLE: if enable & full[rd_bank] -> RUN; fetch_start=1 and fetch_base=rd_bank in the cycle after the condition; watchdog cleared.
REQ-019 RUN: fetch_start and fetch_base SHALL hold; watchdog increments each cycle.
REQ-020 RUN & fetch_done: -> DRAIN; fetch_start=0; full[rd_bank] cleared; rd_bank toggled; frames_out +1.
REQ-021 RUN & watchdog == TIMEOUT_CYCLES-1 without fetch_done: -> DRAIN; fetch_start=0; timeout_err set; full[rd_bank] cleared; rd_bank toggled; frames_out unchanged.
REQ-022 DRAIN: remain until fetch_done==0, then -> IDLE; no new launch before then (minimum one DRAIN cycle).
REQ-023 fetch_done and watchdog expiry in the same cycle: completion (REQ-020) wins, no timeout_err.
REQ-024 Same-cycle wr_bank_done and full clear SHALL both take effect; they always target different banks, since the read bank is full and the write bank is free.
REQ-025 enable deasserted in RUN/DRAIN: current frame completes normally; no new launch.
REQ-026 fetch_done high while IDLE SHALL be ignored.
REQ-027 Watchdog SHALL be 16 bits; it saturates and does not wrap.

Reset
REQ-028 reset_n low SHALL immediately force: state=IDLE, full=2'b00, wr_bank=0, rd_bank=0, fetch_start=0, fetch_base=0, frames_out=0, timeout_err=0, overrun_err=0, busy=0, watchdog=0.
REQ-029 Reset mid-RUN SHALL abandon the frame; fetch_start drops asynchronously; sticky errors clear only by reset.

Structure
REQ-030 Shared package output_sched_pkg SHALL hold the state enumeration (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2) and the TIMEOUT_CYCLES default.
REQ-031 Watchdog SHALL be sub-module output_sched_watchdog (clear, count-enable, terminal-count output).
REQ-032 No other sub-modules; target 150-250 lines RTL total.

Verification
REQ-033 Reset, then pulse wr_bank_done once with enable=1 -> wr_bank=1; fetch_start=1 and fetch_base=0 two cycles after the pulse; busy=1.
REQ-034 Model fetch_done rising 263 cycles after start -> fetch_start=0 next cycle, frames_out=1, full[0]=0, state DRAIN until fetch_done falls, then IDLE.
REQ-035 Fill both banks back-to-back -> third wr_bank_done sets overrun_err, wr_bank_ready=0; after bank 0 completes, wr_bank_ready=1 with wr_bank=0.
REQ-036 TIMEOUT_CYCLES=16, fetch_done held low -> fetch_start drops after 16 RUN cycles, timeout_err=1, frames_out=0, rd_bank=1.
REQ-037 Assert reset_n low mid-RUN -> fetch_start=0 with no clock edge; all outputs at REQ-028 values; no relaunch until a new wr_bank_done.
REQ-038 Complete 256 frames -> frames_out wraps to 8'h00; enable=0 with a full bank -> fetch_start stays 0.
